// File: rtl/stopwatch_ctrl.sv
// Two-button run/stop/lap/reset controller for a BCD stopwatch.
// Debounces both buttons, sequences the counter enable/clear, and picks the live or lap digits for display.
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_ss,
  input  logic        btn_lr,
  input  logic [31:0] cnt_in,
  output logic        sw_en,
  output logic        sw_rst,
  output logic [31:0] disp,
  output logic [1:0]  state,
  output logic [3:0]  lap_cnt
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int BTN_SS = 0;
  localparam int BTN_LR = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_e;

  // Button index 0 is start/stop, index 1 is lap/reset.
  logic [1:0]         sync1_q, sync1_d;
  logic [1:0]         sync2_q, sync2_d;
  logic [1:0]         acc_q, acc_d;
  logic [1:0]         rise_q, rise_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;

  state_e      state_q, state_d;
  logic [3:0]  lap_q, lap_d;
  logic [31:0] hold_q, hold_d;

  logic ss_ev;
  logic lr_ev;

  always_comb begin
    sync1_d = {btn_lr, btn_ss};
    sync2_d = sync1_q;
    acc_d   = acc_q;
    cnt_d   = '0;
    for (int b = 0; b < 2; b++) begin
      // A level is accepted only after DB_CYCLES consecutive disagreeing samples.
      if (sync2_q[b] != acc_q[b]) begin
        if (cnt_q[b] == CW'(DB_CYCLES - 1)) begin
          acc_d[b] = sync2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + CW'(1);
        end
      end
    end
    rise_d = acc_d & ~acc_q;
  end

  assign ss_ev = rise_q[BTN_SS];
  assign lr_ev = rise_q[BTN_LR];

  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    hold_d  = hold_q;
    // Start/stop wins when both events land together; the lap/reset event is dropped.
    unique case (state_q)
      IDLE: begin
        if (ss_ev) state_d = RUN;
      end
      RUN: begin
        if (ss_ev) begin
          state_d = PAUSE;
        end else if (lr_ev) begin
          state_d = LAP;
          hold_d  = cnt_in;
          if (lap_q != 4'd15) lap_d = lap_q + 4'd1;
        end
      end
      LAP: begin
        if (ss_ev) begin
          state_d = PAUSE;
        end else if (lr_ev) begin
          state_d = RUN;
        end
      end
      PAUSE: begin
        if (ss_ev) begin
          state_d = RUN;
        end else if (lr_ev) begin
          state_d = IDLE;
          lap_d   = 4'd0;
          hold_d  = 32'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      acc_q   <= '0;
      rise_q  <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
      lap_q   <= 4'd0;
      hold_q  <= 32'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      acc_q   <= acc_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      lap_q   <= lap_d;
      hold_q  <= hold_d;
    end
  end

  // Moore outputs; the display mux stays combinational so live digits see no extra latency.
  assign sw_en   = (state_q == RUN) || (state_q == LAP);
  assign sw_rst  = (state_q == IDLE);
  assign disp    = (state_q == LAP) ? hold_q : cnt_in;
  assign state   = state_q;
  assign lap_cnt = lap_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Two-button run/stop/lap/reset controller that sequences the stopwatch counter through its `en` and `rst` inputs.
- Debounces both push-buttons and turns each press into a single event.
- Selects what the display shows: the live BCD count, or a frozen lap snapshot.
- Sits between the board buttons and the stopwatch/display path.

Parameters:
- DB_CYCLES, 1_000_000, consecutive stable cycles a synchronized button level must hold before it is accepted (set to 4 for simulation).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- btn_ss  in  1  raw start/stop button, active-high, asynchronous to clk
- btn_lr  in  1  raw lap/reset button, active-high, asynchronous to clk
- cnt_in  in  32  live stopwatch digits, d7 in [31:28] down to d0 in [3:0]
- sw_en  out  1  stopwatch count enable
- sw_rst  out  1  stopwatch clear, active-high
- disp  out  32  digits to display, same packing as cnt_in
- state  out  2  FSM state: IDLE=0, RUN=1, LAP=2, PAUSE=3
- lap_cnt  out  4  number of laps taken since the last clear

Behaviour:
- Reset is synchronous: on any clk edge with rst_n=0:
  - state=IDLE, lap_cnt=0, lap hold register=0;
  - debounce counters=0, accepted levels=0, synchronizer flops=0.
- Debounce, per button, identical logic:
  - 2-flop synchronizer.
  - Counter of width $clog2(DB_CYCLES+1).
  - If the synchronized level differs from the accepted level, the counter increments; otherwise it clears.
  - When the counter reaches DB_CYCLES, the accepted level takes the synchronized level and the counter clears.
  - A press event is a one-cycle pulse on an accepted 0->1 transition. Releases generate no event.
  - Glitches shorter than DB_CYCLES produce no event.
  - Event latency from a raw edge is DB_CYCLES+3 clk edges, +/-1.
- FSM (Moore outputs from the state register) reacts on the edge after an event pulse. If both events are pulsed in the same cycle, ss has priority and lr is dropped.
  - IDLE: ss -> RUN; lr ignored.
  - RUN: ss -> PAUSE. lr -> LAP, and on that edge hold<=cnt_in and lap_cnt<=lap_cnt+1, saturating at 15.
  - LAP: ss -> PAUSE. lr -> RUN (releases the display; no new lap).
  - PAUSE: ss -> RUN. lr -> IDLE, and lap_cnt<=0 and hold<=0 on that edge.
- Outputs:
  - sw_en=1 in RUN and LAP; 0 otherwise.
  - sw_rst=1 in IDLE only, so the stopwatch is held at zero while idle and during reset.
  - disp=hold in LAP; otherwise disp=cnt_in (combinational mux, no added latency).
  - Timing continues while in LAP, because sw_en stays 1.
- Boundaries:
  - Holding a button produces exactly one event; a repeat requires release and re-press.
  - lap_cnt saturates at 15, but hold still relatches on every lap beyond that.
  - Asserting rst_n=0 mid-RUN or mid-LAP gives IDLE on the next edge: sw_en=0, sw_rst=1, disp=cnt_in.
  - The 2-bit state encoding is fully used; there are no illegal states.

Test Plan:
- DB_CYCLES=4. Reset, then pulse btn_ss high for 10 cycles -> state goes 0->1 within 8 cycles of the raw edge. sw_en=1, sw_rst=0, exactly one transition.
- btn_ss glitch high for 3 cycles, in any state -> no state change, sw_en unchanged.
- In RUN with cnt_in=32'h0000_1234, press btn_lr -> state=2, lap_cnt=1, disp=32'h0000_1234. Then drive cnt_in=32'h0000_1299 -> disp stays 1234 and sw_en=1. Press btn_lr again -> state=1, disp=32'h0000_1299.
- RUN -> btn_ss -> PAUSE (sw_en=0). btn_lr -> IDLE: sw_rst=1, lap_cnt=0. A further btn_lr in IDLE -> no change.
- Raw presses on both buttons such that their event pulses land in the same cycle while in RUN -> state=PAUSE, lap_cnt unchanged.
- 17 lap/release cycles in RUN -> lap_cnt=15 (saturated), and hold equals the cnt_in present at the 17th lap. Then assert rst_n=0 for one cycle in LAP -> state=0, lap_cnt=0, disp=cnt_in.
